mode_handover_ctrl: RTL and testbench

Downstream consumer of the single-bit `mode` output of the Avalon PIO. Moves ownership of the shared NovaCORE resource port between the host (mode=1) and the core array (mode=0). The port is only handed over once the current owner's in-flight transactions have drained. It exposes per-side grants plus a small Avalon-MM status slave so software can poll, or take an interrupt, for handover completion.

---
 rtl/mode_handover_pkg.sv | 21 ++
 rtl/mode_handover_ctrl_txn_counter.sv | 54 +++++
 rtl/mode_handover_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mode_handover_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mode_handover_pkg.sv
// Shared types and status-word layout for the mode handover controller.
package mode_handover_pkg;

    typedef enum logic [1:0] {
        OWN_HOST   = 2'd0,
        DRAIN_HOST = 2'd1,
        OWN_CORE   = 2'd2,
        DRAIN_CORE = 2'd3
    } state_t;

    localparam int ST_OWNER     = 0;
    localparam int ST_STATE_LO  = 1;
    localparam int ST_ERR_ISSUE = 3;
    localparam int ST_ERR_UNDER = 4;
    localparam int ST_ERR_SIDE  = 5;
    localparam int ST_DONE      = 6;
    localparam int ST_CNT_LO    = 8;

    localparam logic [1:0] ADDR_STATUS = 2'd0;

endpackage

// File: rtl/mode_handover_ctrl_txn_counter.sv
// Saturating up/down counter of in-flight transactions for the current owner.
module txn_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             is_zero,
    output logic             is_max,
    output logic             next_zero,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             inc_ok_s;
    logic             dec_ok_s;

    assign is_zero   = (cnt_r == CNT_ZERO);
    assign is_max    = (cnt_r == CNT_MAX);
    assign underflow = dec && is_zero;
    assign next_zero = (cnt_next_s == CNT_ZERO);
    assign cnt       = cnt_r;

    // A rejected dec (at zero) must not cancel a simultaneous inc.
    always_comb begin
        inc_ok_s   = inc && !is_max;
        dec_ok_s   = dec && !is_zero;
        cnt_next_s = cnt_r;
        if (inc_ok_s && !dec_ok_s) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else if (dec_ok_s && !inc_ok_s) begin
            cnt_next_s = cnt_r - CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

endmodule

// File: rtl/mode_handover_ctrl.sv
// Hands the shared resource port between host and cores once the owner drains.
// Optional interrupt output is built when MODE_HANDOVER_IRQ_EN is defined.
module mode_handover_ctrl
    import mode_handover_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode,
    input  logic        host_issue,
    input  logic        host_done,
    input  logic        core_issue,
    input  logic        core_done,
    output logic        host_grant,
    output logic        core_grant,
    output logic        sel_core,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_s;
    logic             is_max_s;
    logic             next_zero_s;
    logic             underflow_s;
    logic             unused_zero_s;
    logic             host_owns_s;
    logic             inc_s;
    logic             dec_s;
    logic             handover_s;
    logic [3:0]       flag_set_s;
    logic [3:0]       flag_clr_s;
    logic [3:0]       flags_r;
    logic [31:0]      status_s;
    logic             unused_wdata_s;

    assign host_owns_s = (state_r == OWN_HOST) || (state_r == DRAIN_HOST);
    assign sel_core    = !host_owns_s;
    assign host_grant  = (state_r == OWN_HOST) && !is_max_s;
    assign core_grant  = (state_r == OWN_CORE) && !is_max_s;
    assign inc_s       = host_owns_s ? (host_issue && host_grant) : (core_issue && core_grant);
    assign dec_s       = host_owns_s ? host_done : core_done;

    txn_counter #(.CNT_W(CNT_W)) u_txn_counter (
        .clk       (clk),
        .reset     (reset),
        .inc       (inc_s),
        .dec       (dec_s),
        .cnt       (cnt_s),
        .is_zero   (unused_zero_s),
        .is_max    (is_max_s),
        .next_zero (next_zero_s),
        .underflow (underflow_s)
    );

    // Ownership state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= OWN_HOST;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Drains complete on the edge of the last done; a mode flip-back aborts.
    always_comb begin
        state_next_s = state_r;
        handover_s   = 1'b0;
        case (state_r)
            OWN_HOST: begin
                if (!mode) state_next_s = DRAIN_HOST;
                else       state_next_s = OWN_HOST;
            end
            DRAIN_HOST: begin
                if (mode) begin
                    state_next_s = OWN_HOST;
                end else if (next_zero_s) begin
                    state_next_s = OWN_CORE;
                    handover_s   = 1'b1;
                end else begin
                    state_next_s = DRAIN_HOST;
                end
            end
            OWN_CORE: begin
                if (mode) state_next_s = DRAIN_CORE;
                else      state_next_s = OWN_CORE;
            end
            DRAIN_CORE: begin
                if (!mode) begin
                    state_next_s = OWN_CORE;
                end else if (next_zero_s) begin
                    state_next_s = OWN_HOST;
                    handover_s   = 1'b1;
                end else begin
                    state_next_s = DRAIN_CORE;
                end
            end
            default: begin
                state_next_s = OWN_HOST;
                handover_s   = 1'b0;
            end
        endcase
    end

    // Flag vector order: {done, err_side, err_under, err_issue}.
    always_comb begin
        flag_set_s[0] = (host_issue && !host_grant) || (core_issue && !core_grant);
        flag_set_s[1] = underflow_s;
        flag_set_s[2] = host_owns_s ? core_done : host_done;
        flag_set_s[3] = handover_s;
        if (chipselect && !write_n && (address == ADDR_STATUS)) begin
            flag_clr_s = writedata[ST_DONE:ST_ERR_ISSUE];
        end else begin
            flag_clr_s = 4'b0000;
        end
    end

    // Sticky flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r <= 4'b0000;
        end else begin
            flags_r <= flag_set_s | (flags_r & ~flag_clr_s);
        end
    end

    assign unused_wdata_s = ^{writedata[31:ST_DONE+1], writedata[ST_ERR_ISSUE-1:0], unused_zero_s};

    // Status word assembly and address decode.
    always_comb begin
        status_s                          = 32'h0000_0000;
        status_s[ST_OWNER]                = sel_core;
        status_s[ST_STATE_LO +: 2]        = state_r;
        status_s[ST_ERR_ISSUE]            = flags_r[0];
        status_s[ST_ERR_UNDER]            = flags_r[1];
        status_s[ST_ERR_SIDE]             = flags_r[2];
        status_s[ST_DONE]                 = flags_r[3];
        status_s[ST_CNT_LO +: CNT_W]      = cnt_s;
        if (address == ADDR_STATUS) begin
            readdata = status_s;
        end else begin
            readdata = 32'h0000_0000;
        end
    end

`ifdef MODE_HANDOVER_IRQ_EN
    logic irq_r;

    // Interrupt trails done_flag by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= flags_r[3];
        end
    end

    assign irq = irq_r;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mode_handover_ctrl.sv
// Self-checking bench: directed vector table, reset corner case, then random vs a reference model.
module tb_mode_handover_ctrl;

    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef MODE_HANDOVER_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic        host_issue, host_done, core_issue, core_done;
    logic        host_grant, core_grant, sel_core, irq;
    logic [1:0]  address;
    logic        chipselect, write_n;
    logic [31:0] writedata, readdata;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mode_handover_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .host_issue (host_issue),
        .host_done  (host_done),
        .core_issue (core_issue),
        .core_done  (core_done),
        .host_grant (host_grant),
        .core_grant (core_grant),
        .sel_core   (sel_core),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    typedef struct {
        logic        mode, hi, hd, ci, cd, wr;
        logic [31:0] wd;
        logic        hg, cg, sel;
        logic [31:0] st;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic m, hi, hd, ci, cd, wr, input logic [31:0] wd,
                       input logic hg, cg, sel, input logic [31:0] st);
        vec_t v;
        v.mode = m; v.hi = hi; v.hd = hd; v.ci = ci; v.cd = cd; v.wr = wr; v.wd = wd;
        v.hg = hg; v.cg = cg; v.sel = sel; v.st = st;
        vt.push_back(v);
    endtask

    // Reference model: owner (0 host, 1 cores), draining, outstanding count, flags.
    bit       m_owner, m_drain, m_irq;
    int       m_cnt;
    bit [3:0] m_flags;

    task automatic m_reset();
        m_owner = 1'b0; m_drain = 1'b0; m_cnt = 0; m_flags = 4'b0; m_irq = 1'b0;
    endtask

    function automatic bit m_hg();
        return !m_owner && !m_drain && (m_cnt != MAXC);
    endfunction

    function automatic bit m_cg();
        return m_owner && !m_drain && (m_cnt != MAXC);
    endfunction

    function automatic logic [31:0] m_status(input logic [1:0] addr);
        logic [31:0] st;
        st = 32'h0;
        if (addr == 2'd0) begin
            st[0]            = m_owner;
            st[2:1]          = {m_owner, m_drain};
            st[6:3]          = m_flags;
            st[8 +: CNT_W]   = m_cnt[CNT_W-1:0];
        end
        return st;
    endfunction

    task automatic m_step(input bit md, hi, hd, ci, cd, input bit [3:0] clr);
        bit hg, cg, own_issue, own_done, e_issue, e_side, e_under, ho, want_core;
        int nc;
        hg        = m_hg();
        cg        = m_cg();
        e_issue   = (hi && !hg) || (ci && !cg);
        own_issue = m_owner ? (ci && cg) : (hi && hg);
        own_done  = m_owner ? cd : hd;
        e_side    = m_owner ? hd : cd;
        e_under   = own_done && (m_cnt == 0);
        nc        = m_cnt + (own_issue ? 1 : 0) - ((own_done && m_cnt > 0) ? 1 : 0);
        want_core = !md;
        ho        = 1'b0;
        if (!m_drain) begin
            if (want_core != m_owner) m_drain = 1'b1;
        end else if (want_core == m_owner) begin
            m_drain = 1'b0;
        end else if (nc == 0) begin
            m_owner = !m_owner;
            m_drain = 1'b0;
            ho      = 1'b1;
        end
        m_irq   = IRQ_EN ? m_flags[3] : 1'b0;
        m_flags = {ho, e_side, e_under, e_issue} | (m_flags & ~clr);
        m_cnt   = nc;
    endtask

    task automatic idle_inputs();
        host_issue = 1'b0; host_done = 1'b0; core_issue = 1'b0; core_done = 1'b0;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0; address = 2'd0;
    endtask

    initial begin
        reset = 1'b1;
        mode  = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset_host_grant", 32'(host_grant), 32'd1);
        check("reset_core_grant", 32'(core_grant), 32'd0);
        check("reset_sel_core",   32'(sel_core),   32'd0);
        check("reset_status",     readdata,        32'h0);
        check("reset_irq",        32'(irq),        32'd0);

        //   mode hi hd ci cd wr wd       hg cg sel status
        add(1, 1, 0, 0, 0, 0, 32'h00, 1, 0, 0, 32'h100);
        add(1, 1, 0, 0, 0, 0, 32'h00, 1, 0, 0, 32'h200);
        add(1, 1, 0, 0, 0, 0, 32'h00, 0, 0, 0, 32'h300);
        add(1, 1, 0, 0, 0, 0, 32'h00, 0, 0, 0, 32'h308);
        add(1, 0, 0, 0, 0, 1, 32'h08, 0, 0, 0, 32'h300);
        add(1, 0, 1, 0, 0, 0, 32'h00, 1, 0, 0, 32'h200);
        add(0, 0, 0, 0, 0, 0, 32'h00, 0, 0, 0, 32'h202);
        add(0, 0, 1, 0, 0, 0, 32'h00, 0, 0, 0, 32'h102);
        add(0, 0, 0, 0, 0, 0, 32'h00, 0, 0, 0, 32'h102);
        add(0, 0, 1, 0, 0, 0, 32'h00, 0, 1, 1, 32'h045);
        add(0, 0, 0, 0, 0, 1, 32'h40, 0, 1, 1, 32'h005);
        add(0, 0, 1, 0, 0, 0, 32'h00, 0, 1, 1, 32'h025);
        add(0, 0, 0, 0, 1, 0, 32'h00, 0, 1, 1, 32'h035);
        add(0, 0, 0, 0, 0, 1, 32'h30, 0, 1, 1, 32'h005);
        add(0, 0, 0, 1, 0, 0, 32'h00, 0, 1, 1, 32'h105);
        add(0, 0, 0, 1, 1, 0, 32'h00, 0, 1, 1, 32'h105);
        add(1, 0, 0, 0, 0, 0, 32'h00, 0, 0, 1, 32'h107);
        add(1, 0, 0, 0, 1, 0, 32'h00, 1, 0, 0, 32'h040);
        add(1, 0, 0, 0, 0, 1, 32'h78, 1, 0, 0, 32'h000);
        add(1, 1, 0, 0, 0, 0, 32'h00, 1, 0, 0, 32'h100);
        add(1, 1, 0, 0, 0, 0, 32'h00, 1, 0, 0, 32'h200);
        add(0, 0, 0, 0, 0, 0, 32'h00, 0, 0, 0, 32'h202);
        add(1, 0, 0, 0, 0, 0, 32'h00, 1, 0, 0, 32'h200);
        add(1, 0, 1, 0, 0, 0, 32'h00, 1, 0, 0, 32'h100);
        add(1, 0, 1, 0, 0, 0, 32'h00, 1, 0, 0, 32'h000);
        add(1, 0, 0, 0, 1, 0, 32'h00, 1, 0, 0, 32'h020);
        add(1, 0, 0, 0, 0, 1, 32'h20, 1, 0, 0, 32'h000);
        add(0, 0, 0, 0, 0, 0, 32'h00, 0, 0, 0, 32'h002);
        add(0, 0, 0, 0, 0, 0, 32'h00, 0, 1, 1, 32'h045);
        add(1, 0, 0, 0, 0, 1, 32'h40, 0, 0, 1, 32'h007);
        add(1, 0, 0, 0, 0, 0, 32'h00, 1, 0, 0, 32'h040);
        add(1, 0, 0, 0, 0, 1, 32'h40, 1, 0, 0, 32'h000);

        for (int i = 0; i < vt.size(); i++) begin
            mode       = vt[i].mode;
            host_issue = vt[i].hi;
            host_done  = vt[i].hd;
            core_issue = vt[i].ci;
            core_done  = vt[i].cd;
            chipselect = vt[i].wr;
            write_n    = !vt[i].wr;
            writedata  = vt[i].wd;
            address    = 2'd0;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_host_grant", i), 32'(host_grant), 32'(vt[i].hg));
            check($sformatf("vec%0d_core_grant", i), 32'(core_grant), 32'(vt[i].cg));
            check($sformatf("vec%0d_sel_core", i),   32'(sel_core),   32'(vt[i].sel));
            check($sformatf("vec%0d_status", i),     readdata,        vt[i].st);
        end

        // Drain with rejected issue plus non-owner done, then asynchronous reset mid-drain.
        idle_inputs();
        mode = 1'b1;
        host_issue = 1'b1;
        repeat (2) @(posedge clk);
        #1 host_issue = 1'b0;
        mode = 1'b0;
        @(posedge clk);
        #1;
        check("drain_enter_status", readdata, 32'h202);
        core_issue = 1'b1;
        core_done  = 1'b1;
        @(posedge clk);
        #1;
        check("drain_issue_done_status", readdata, 32'h22A);
        core_issue = 1'b0;
        core_done  = 1'b0;
        host_issue = 1'b1;
        @(posedge clk);
        #1;
        check("drain_host_issue_status", readdata, 32'h22A);
        host_issue = 1'b0;
        mode = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("async_reset_host_grant", 32'(host_grant), 32'd1);
        check("async_reset_core_grant", 32'(core_grant), 32'd0);
        check("async_reset_sel_core",   32'(sel_core),   32'd0);
        check("async_reset_status",     readdata,        32'h0);
        check("async_reset_irq",        32'(irq),        32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        m_reset();

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            bit [3:0] clr;
            if ($urandom_range(7) == 0) mode = ~mode;
            host_issue = 1'($urandom_range(1));
            host_done  = 1'($urandom_range(1));
            core_issue = 1'($urandom_range(1));
            core_done  = 1'($urandom_range(2) == 0);
            chipselect = 1'($urandom_range(3) == 0);
            write_n    = 1'($urandom_range(1));
            address    = 2'($urandom_range(3));
            writedata  = $urandom;
            clr = (chipselect && !write_n && address == 2'd0) ? writedata[6:3] : 4'b0;
            @(posedge clk);
            m_step(mode, host_issue, host_done, core_issue, core_done, clr);
            #1;
            check($sformatf("rnd%0d_host_grant", i), 32'(host_grant), 32'(m_hg()));
            check($sformatf("rnd%0d_core_grant", i), 32'(core_grant), 32'(m_cg()));
            check($sformatf("rnd%0d_sel_core", i),   32'(sel_core),   32'(m_owner));
            check($sformatf("rnd%0d_readdata", i),   readdata,        m_status(address));
            check($sformatf("rnd%0d_irq", i),        32'(irq),        32'(m_irq));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
